// File: rtl/board_mem_arbiter.sv
// rtl/board_mem_arbiter.sv - Connect4 board store with display/game arbitration and clear sequencer (option: BOARD_BLANK_WRITE_EN)
module board_mem_arbiter #(
    parameter int COLS   = 7,
    parameter int ROWS   = 6,
    parameter int CELL_W = 2,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [CELL_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [CELL_W-1:0] game_wdata,
    output logic              game_ack,
    output logic [CELL_W-1:0] game_rdata,
    input  logic              clear_start,
    output logic              busy,
    input  logic              vblank,
    output logic [7:0]        stall_cnt
);

    localparam int NCELLS = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCELLS - 1);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [CELL_W-1:0] cells_q [NCELLS];
    logic [CELL_W-1:0] cells_d [NCELLS];
    logic              disp_valid_q, disp_valid_d;
    logic [CELL_W-1:0] disp_data_q, disp_data_d;
    logic              game_ack_q, game_ack_d;
    logic [CELL_W-1:0] game_rdata_q, game_rdata_d;
    logic [7:0]        stall_q, stall_d;

    logic in_idle;
    logic write_gate;
    logic game_grant;
    logic disp_in_range;
    logic game_in_range;

    assign in_idle       = (state_q == ST_IDLE);
    assign disp_in_range = (disp_addr <= LAST_ADDR);
    assign game_in_range = (game_addr <= LAST_ADDR);

`ifdef BOARD_BLANK_WRITE_EN
    // Writes wait for vertical blanking so the board never changes mid-frame.
    assign write_gate = !game_we || vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign write_gate    = 1'b1;
`endif

    // Display always wins; a clear request in the same cycle also blocks the game port,
    // and the ack cycle itself never grants so each transaction completes before the next.
    assign game_grant = in_idle && !clear_start && game_req && !disp_req
                        && !game_ack_q && write_gate;

    // Next state of the sequencer and the single store write port.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        cells_d   = cells_q;
        if (in_idle) begin
            if (clear_start) begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end else if (game_grant && game_we && game_in_range) begin
                cells_d[game_addr] = game_wdata;
            end
        end else begin
            cells_d[clr_cnt_q] = '0;
            if (clr_cnt_q == LAST_ADDR) begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + 1'b1;
            end
        end
    end

    // Registered read responses; data is forced to 0 outside its valid/ack cycle.
    always_comb begin
        disp_valid_d = disp_req;
        disp_data_d  = (disp_req && in_idle && disp_in_range) ? cells_q[disp_addr] : '0;
        game_ack_d   = game_grant;
        game_rdata_d = (game_grant && !game_we && game_in_range) ? cells_q[game_addr] : '0;
        if (game_grant) begin
            stall_d = '0;
        end else if (game_req && (stall_q != 8'hFF)) begin
            stall_d = stall_q + 8'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // State, store and output registers; reset empties the board and abandons any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            clr_cnt_q    <= '0;
            for (int i = 0; i < NCELLS; i++) begin
                cells_q[i] <= '0;
            end
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            game_ack_q   <= 1'b0;
            game_rdata_q <= '0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            cells_q      <= cells_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            game_ack_q   <= game_ack_d;
            game_rdata_q <= game_rdata_d;
            stall_q      <= stall_d;
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign game_ack   = game_ack_q;
    assign game_rdata = game_rdata_q;
    assign busy       = (state_q == ST_CLEAR);
    assign stall_cnt  = stall_q;

endmodule
